// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the in-order load/store unit.
// Holds access-size encodings, the ordering-queue entry kind, the
// request FSM state type and the combinational helpers for alignment,
// store-lane replication and load-data extraction.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        KIND_LOAD  = 2'd0,
        KIND_STORE = 2'd1,
        KIND_PASS  = 2'd2
    } kind_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_ADDR = 1'b1
    } req_state_e;

    // Half must be 2-byte aligned, word 4-byte aligned; bytes never fault.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Replicate low-aligned store data across all byte lanes.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{wdata[7:0]}};
            SZ_HALF: lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    // Shift the addressed bytes down, then sign- or zero-extend.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] offset,
                                                 input logic [1:0] size, input logic is_unsigned);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {offset, 3'b000};
        case (size)
            SZ_BYTE: res = is_unsigned ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = is_unsigned ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_idx_fifo.sv
// Index FIFO: remembers, in bus-issue order, which ordering-queue entry
// each accepted bus request belongs to, so in-order responses can be
// steered back to their entry.
// Ports: clk, reset (sync, active high), push/push_idx, pop/pop_idx
// (head index, valid when !empty), full, empty.
module lsu_idx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_idx,
    input  logic         pop,
    output logic [W-1:0] pop_idx,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [W-1:0]   mem_r [DEPTH];
    logic [PTR_W:0] wr_ptr_r;
    logic [PTR_W:0] rd_ptr_r;

    // Pointer advance and storage write; the extra pointer bit separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (push && !full) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= push_idx;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign pop_idx = mem_r[rd_ptr_r[PTR_W-1:0]];
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);

endmodule

// File: rtl/mem_lsu.sv
// In-order load/store unit. Ops arrive from EXE on a valid/ready handshake,
// occupy an ordering-queue entry, and bus ops are issued on an sram_like
// bus with pipelined address and data phases. Results leave to WB strictly
// in program order from the queue head. cancel kills every undelivered
// entry; a request already on the bus is held until accepted and its
// response is absorbed by its killed entry.
// Ports: clk/reset; EXE side in_* with in_ready; cancel; bus side data_*;
// WB side out_* with out_ready; busy.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          TAG_W     = 48,
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_load,
    input  logic             in_store,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_wdata,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             cancel,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    input  logic [31:0]      data_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_adel,
    output logic             out_ades,
    output logic [31:0]      out_badvaddr,
    output logic             busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Ordering queue. q_data_r holds load rdata, or the unmasked address
    // for pass-through ops and faulting ops.
    logic [TAG_W-1:0] q_tag_r    [DEPTH];
    logic [1:0]       q_size_r   [DEPTH];
    logic [1:0]       q_off_r    [DEPTH];
    logic             q_uns_r    [DEPTH];
    kind_e            q_kind_r   [DEPTH];
    logic             q_exc_r    [DEPTH];
    logic             q_done_r   [DEPTH];
    logic             q_killed_r [DEPTH];
    logic [31:0]      q_data_r   [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;

    req_state_e       state_r;
    req_state_e       state_nx_s;
    logic [31:0]      req_addr_r;
    logic [31:0]      req_wdata_r;
    logic [1:0]       req_size_r;
    logic             req_wr_r;
    logic [PTR_W-1:0] req_idx_r;

    logic [PTR_W-1:0] wr_idx_s;
    logic [PTR_W-1:0] hd_idx_s;
    logic [PTR_W-1:0] rsp_idx_s;
    logic             q_empty_s;
    logic             q_full_s;
    logic             idx_full_s;
    logic             idx_empty_s;
    kind_e            in_kind_s;
    logic             in_mis_s;
    logic             in_bus_s;
    logic             acc_s;
    logic             bus_acc_s;
    logic             addr_hs_s;
    logic             head_done_s;
    logic             pop_s;

    assign wr_idx_s  = wr_ptr_r[PTR_W-1:0];
    assign hd_idx_s  = rd_ptr_r[PTR_W-1:0];
    assign q_empty_s = (wr_ptr_r == rd_ptr_r);
    assign q_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) && (wr_idx_s == hd_idx_s);

    // Classify the offered op.
    always_comb begin
        in_kind_s = KIND_PASS;
        if (in_load) begin
            in_kind_s = KIND_LOAD;
        end else if (in_store) begin
            in_kind_s = KIND_STORE;
        end else begin
            in_kind_s = KIND_PASS;
        end
    end

    assign in_mis_s  = is_misaligned(in_size, in_addr[1:0]);
    assign in_bus_s  = (in_kind_s != KIND_PASS) && !in_mis_s;
    // A new bus op can only be taken when the request register is free
    // or is being handed to the bus this very cycle.
    assign in_ready  = !cancel && !q_full_s && !idx_full_s &&
                       ((state_r == ST_IDLE) || data_addr_ok);
    assign acc_s     = in_valid && in_ready;
    assign bus_acc_s = acc_s && in_bus_s;
    assign addr_hs_s = (state_r == ST_WAIT_ADDR) && data_addr_ok;

    // Request FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Request FSM next state and bus request strobe.
    always_comb begin
        state_nx_s = state_r;
        data_req   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus_acc_s) begin
                    state_nx_s = ST_WAIT_ADDR;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT_ADDR: begin
                data_req = 1'b1;
                if (data_addr_ok) begin
                    state_nx_s = bus_acc_s ? ST_WAIT_ADDR : ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_ADDR;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Request register: loaded on issue, frozen until the bus accepts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr_r  <= 32'd0;
            req_wdata_r <= 32'd0;
            req_size_r  <= SZ_BYTE;
            req_wr_r    <= 1'b0;
            req_idx_r   <= {PTR_W{1'b0}};
        end else if (bus_acc_s) begin
            req_addr_r  <= in_addr & ADDR_MASK;
            req_wdata_r <= store_lanes(in_size, in_wdata);
            req_size_r  <= in_size;
            req_wr_r    <= (in_kind_s == KIND_STORE);
            req_idx_r   <= wr_idx_s;
        end
    end

    assign data_addr  = req_addr_r;
    assign data_wdata = req_wdata_r;
    assign data_size  = req_size_r;
    assign data_wr    = req_wr_r;

    lsu_idx_fifo #(
        .DEPTH (DEPTH),
        .W     (PTR_W)
    ) u_idx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (addr_hs_s),
        .push_idx (req_idx_r),
        .pop      (data_data_ok),
        .pop_idx  (rsp_idx_s),
        .full     (idx_full_s),
        .empty    (idx_empty_s)
    );

    assign head_done_s = !q_empty_s && q_done_r[hd_idx_s];
    assign out_valid   = head_done_s && !q_killed_r[hd_idx_s] && !cancel;
    // Killed entries leave the head silently once their bus traffic is over.
    assign pop_s       = (out_valid && out_ready) || (head_done_s && q_killed_r[hd_idx_s]);

    // Ordering-queue allocation, response capture, retirement and kill.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_done_r[i]   <= 1'b0;
                q_killed_r[i] <= 1'b0;
            end
        end else begin
            if (acc_s) begin
                q_tag_r[wr_idx_s]    <= in_tag;
                q_size_r[wr_idx_s]   <= in_size;
                q_off_r[wr_idx_s]    <= in_addr[1:0];
                q_uns_r[wr_idx_s]    <= in_unsigned;
                q_kind_r[wr_idx_s]   <= in_kind_s;
                q_exc_r[wr_idx_s]    <= (in_kind_s != KIND_PASS) && in_mis_s;
                q_done_r[wr_idx_s]   <= !in_bus_s;
                q_killed_r[wr_idx_s] <= 1'b0;
                q_data_r[wr_idx_s]   <= in_addr;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (data_data_ok && !idx_empty_s) begin
                q_data_r[rsp_idx_s] <= data_rdata;
                q_done_r[rsp_idx_s] <= 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (cancel) begin
                for (int i = 0; i < DEPTH; i++) begin
                    q_killed_r[i] <= 1'b1;
                end
            end
        end
    end

    assign out_tag = q_tag_r[hd_idx_s];

    // WB payload decoded from the head entry.
    always_comb begin
        out_result   = 32'd0;
        out_adel     = 1'b0;
        out_ades     = 1'b0;
        out_badvaddr = 32'd0;
        if (q_exc_r[hd_idx_s]) begin
            out_adel     = (q_kind_r[hd_idx_s] == KIND_LOAD);
            out_ades     = (q_kind_r[hd_idx_s] == KIND_STORE);
            out_badvaddr = q_data_r[hd_idx_s];
        end else begin
            case (q_kind_r[hd_idx_s])
                KIND_LOAD:  out_result = load_extract(q_data_r[hd_idx_s], q_off_r[hd_idx_s],
                                                      q_size_r[hd_idx_s], q_uns_r[hd_idx_s]);
                KIND_PASS:  out_result = q_data_r[hd_idx_s];
                default:    out_result = 32'd0;
            endcase
        end
    end

    assign busy = !q_empty_s || (state_r == ST_WAIT_ADDR);

endmodule
